// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with stall, flush-to-bubble, sticky halt freeze and saturating bubble count.
// Latency: one enabled rising edge from any *_in to its *_out; all outputs are registered.
// Backpressure: en=0 holds every output; flush squashes to a bubble; a latched halt freezes the stage until RST.
module id_ex_latch #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [3:0]        aluop_in,
    input  logic              regwr_in,
    input  logic              memrd_in,
    input  logic              memwr_in,
    input  logic [1:0]        memtoreg_in,
    input  logic [1:0]        alusrc_in,
    input  logic [1:0]        regdst_in,
    input  logic              halt_in,
    input  logic [WORD_W-1:0] rdat1_in,
    input  logic [WORD_W-1:0] rdat2_in,
    input  logic [WORD_W-1:0] imm_in,
    input  logic [WORD_W-1:0] npc_in,
    input  logic [4:0]        rs_in,
    input  logic [4:0]        rt_in,
    input  logic [4:0]        rd_in,
    input  logic [4:0]        shamt_in,
    output logic              valid_out,
    output logic [3:0]        aluop_out,
    output logic              regwr_out,
    output logic              memrd_out,
    output logic              memwr_out,
    output logic [1:0]        memtoreg_out,
    output logic [1:0]        alusrc_out,
    output logic [1:0]        regdst_out,
    output logic              halt_out,
    output logic [WORD_W-1:0] rdat1_out,
    output logic [WORD_W-1:0] rdat2_out,
    output logic [WORD_W-1:0] imm_out,
    output logic [WORD_W-1:0] npc_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic [4:0]        shamt_out,
    output logic [15:0]       bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [3:0]        aluop;
        logic              regwr;
        logic              memrd;
        logic              memwr;
        logic [1:0]        memtoreg;
        logic [1:0]        alusrc;
        logic [1:0]        regdst;
        logic              halt;
        logic [WORD_W-1:0] rdat1;
        logic [WORD_W-1:0] rdat2;
        logic [WORD_W-1:0] imm;
        logic [WORD_W-1:0] npc;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
    } stage_t;

    stage_t      r_q;
    stage_t      w_load;
    logic [15:0] r_bubble_cnt;
    logic        w_frozen;
    logic        w_bubble;

    // A latched halt freezes the whole stage; only RST releases it.
    assign w_frozen = r_q.halt;

    // A bubble enters on a squash, or on an advance carrying no real instruction.
    assign w_bubble = !w_frozen && (flush || (en && !valid_in));

    // Build the value an enabled edge loads; side-effecting enables are gated by valid_in.
    always_comb begin
        w_load          = '0;
        w_load.valid    = valid_in;
        w_load.aluop    = aluop_in;
        w_load.regwr    = regwr_in & valid_in;
        w_load.memrd    = memrd_in & valid_in;
        w_load.memwr    = memwr_in & valid_in;
        w_load.memtoreg = memtoreg_in;
        w_load.alusrc   = alusrc_in;
        w_load.regdst   = regdst_in;
        w_load.halt     = halt_in & valid_in;
        w_load.rdat1    = rdat1_in;
        w_load.rdat2    = rdat2_in;
        w_load.imm      = imm_in;
        w_load.npc      = npc_in;
        w_load.rs       = rs_in;
        w_load.rt       = rt_in;
        w_load.rd       = rd_in;
        w_load.shamt    = shamt_in;
    end

    // Stage register: reset > halt freeze > flush > advance > hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= '0;
        end else if (w_frozen) begin
            r_q <= r_q;
        end else if (flush) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_load;
        end
    end

    // Saturating count of bubbles inserted; never wraps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign valid_out    = r_q.valid;
    assign aluop_out    = r_q.aluop;
    assign regwr_out    = r_q.regwr;
    assign memrd_out    = r_q.memrd;
    assign memwr_out    = r_q.memwr;
    assign memtoreg_out = r_q.memtoreg;
    assign alusrc_out   = r_q.alusrc;
    assign regdst_out   = r_q.regdst;
    assign halt_out     = r_q.halt;
    assign rdat1_out    = r_q.rdat1;
    assign rdat2_out    = r_q.rdat2;
    assign imm_out      = r_q.imm;
    assign npc_out      = r_q.npc;
    assign rs_out       = r_q.rs;
    assign rt_out       = r_q.rt;
    assign rd_out       = r_q.rd;
    assign shamt_out    = r_q.shamt;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: doc/id_ex_latch.md
ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 Parameter WORD_W, default 32: datapath word width.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 en  in  1  advance strobe from the hazard/memory-wait logic.
REQ-006 flush  in  1  squash request; inserts a bubble.
REQ-007 valid_in  in  1  decode-stage contents are a real instruction.
REQ-008 aluop_in  in  4  ALU operation from the control unit.
REQ-009 regwr_in, memrd_in, memwr_in  in  1 each  control-unit write/load/store enables.
REQ-010 memtoreg_in, alusrc_in, regdst_in  in  2 each  control-unit mux selects.
REQ-011 halt_in  in  1  control-unit HALT decode.
REQ-012 rdat1_in, rdat2_in, imm_in, npc_in  in  WORD_W each  operands, extended immediate, PC+4.
REQ-013 rs_in, rt_in, rd_in, shamt_in  in  5 each  instruction fields.
REQ-014 Each *_in above has a registered *_out twin (same width); valid_out  out  1.
REQ-015 halt_out  out  1  sticky halt to the downstream stage.
REQ-016 bubble_cnt  out  16  saturating count of bubbles inserted.

Function
REQ-017 All *_out SHALL be registered; no combinational path from any input to any output.
REQ-018 Priority per edge SHALL be: RST > halt_out frozen > flush > en > hold.
REQ-019 flush=1: all control outputs (regwr, memrd, memwr, halt, valid) SHALL clear to 0 on that edge regardless of en; data outputs SHALL clear to 0.
REQ-020 flush=0, en=1: every *_out SHALL load its *_in on that edge; valid_out<=valid_in.
REQ-021 flush=0, en=0: all outputs SHALL hold (stall); latency in->out is exactly one enabled edge.
REQ-022 en=1, valid_in=0: control enables regwr/memrd/memwr/halt SHALL load as 0 (bubble) even if asserted at input; data fields still load.
REQ-023 halt_out SHALL set when an enabled, unflushed edge loads halt_in=1 with valid_in=1.
REQ-024 Once halt_out=1, all outputs SHALL freeze (en and flush ignored) until RST.
REQ-025 bubble_cnt SHALL increment by 1 on every edge where a bubble enters: flush=1, or en=1 with valid_in=0; not while frozen by halt.
REQ-026 bubble_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-027 Stall and bubble on the same edge (en=0, flush=0): hold; no increment.

Reset
REQ-028 RST=1 at an edge SHALL clear every output, valid_out, halt_out and bubble_cnt to 0, overriding en, flush and halt freeze.
REQ-029 RST asserted mid-stall or after halt SHALL release the freeze; first post-reset enabled edge loads normally.

Verification
REQ-030 Load: RST then en=1, valid_in=1, aluop_in=ADDU code, rdat1_in=32'h5, regwr_in=1 -> after one edge aluop_out=ADDU, rdat1_out=32'h5, regwr_out=1, valid_out=1.
REQ-031 Stall: load as above, then en=0 and change rdat1_in=32'hA for 3 edges -> rdat1_out stays 32'h5, bubble_cnt stays 0.
REQ-032 Flush vs en: en=1, flush=1, memwr_in=1, valid_in=1 -> memwr_out=0, valid_out=0, bubble_cnt increments 0->1.
REQ-033 Invalid input: en=1, valid_in=0, regwr_in=1, memwr_in=1 -> regwr_out=0, memwr_out=0, bubble_cnt+1.
REQ-034 Halt: en=1, valid_in=1, halt_in=1 -> halt_out=1; next edges with en=1, flush=1, new data -> all outputs unchanged, bubble_cnt unchanged; RST -> all 0.
REQ-035 Saturation: force 65537 flush edges -> bubble_cnt=16'hFFFF, no wrap to 0.
